bcd_to_binary: RTL and testbench

Sequential converter from eight packed BCD digits to a 27-bit binary value. It uses reverse double-dabble: shift right, then subtract 3 from any digit that is 8 or more. It is the input-side counterpart of the display path. Decimal operands entered on switches or a keypad as BCD are converted to binary before reaching the GCD datapath. The digit layout and the 4'hF blank code are identical to what the display BCD encoder emits, so display data can be fed back directly.

---
 rtl/bcd_to_binary_if.sv | 24 ++
 rtl/bcd_to_binary.sv | 126 ++++++++++++
 tb/tb_bcd_to_binary.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_to_binary_if.sv
// Handshake and data bundle between a BCD operand source and the bcd_to_binary
// converter. The master drives start/digits; the slave (converter) returns the
// result, status and completion pulse.
interface bcd_to_binary_if #(
  parameter int unsigned Digits = 8,
  parameter int unsigned Width  = 27
);
  logic                  start;
  logic [4*Digits-1:0]   digits;
  logic [Width-1:0]      binary;
  logic                  busy;
  logic                  done;
  logic                  err;

  modport master (
    output start, digits,
    input  binary, busy, done, err
  );

  modport slave (
    input  start, digits,
    output binary, busy, done, err
  );
endinterface

// File: rtl/bcd_to_binary.sv
// Sequential packed-BCD to binary converter using reverse double-dabble:
// shift {bcd, acc} right by one per cycle, then subtract 3 from every BCD
// digit that is 8 or more. Digit layout and the 4'hF blank code match the
// display encoder so its output can be fed straight back in.
// Optional feature macro: BCD2BIN_BLANK_EN -- when defined, digit code 4'hF is
// read as 0 at capture instead of being flagged as an invalid digit.
module bcd_to_binary #(
  parameter int unsigned Digits = 8,
  parameter int unsigned Width  = 27
) (
  input logic             clk,
  input logic             rst,
  bcd_to_binary_if.slave  bus
);

  localparam int unsigned BcdW = 4 * Digits;
  localparam int unsigned CntW = $clog2(Width + 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e            state_q, state_d;
  logic [BcdW-1:0]   bcd_q, bcd_d;
  logic [Width-1:0]  acc_q, acc_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              err_flag_q, err_flag_d;
  logic [Width-1:0]  binary_q, binary_d;
  logic              err_q, err_d;
  logic              done_q, done_d;

  logic [BcdW-1:0]   cap_bcd;
  logic              cap_bad;
  logic [BcdW-1:0]   sh_bcd;
  logic [Width-1:0]  sh_acc;

  function automatic logic [3:0] fix_digit(input logic [3:0] d);
`ifdef BCD2BIN_BLANK_EN
    return (d == 4'hF) ? 4'h0 : d;
`else
    return d;
`endif
  endfunction

  // Operand as it would be captured now, plus whether any digit is illegal.
  always_comb begin
    cap_bcd = '0;
    cap_bad = 1'b0;
    for (int k = 0; k < Digits; k++) begin
      cap_bcd[4*k +: 4] = fix_digit(bus.digits[4*k +: 4]);
      if (cap_bcd[4*k +: 4] > 4'd9) cap_bad = 1'b1;
    end
  end

  // One reverse double-dabble step: right shift, then per-digit -3 correction.
  always_comb begin
    {sh_bcd, sh_acc} = {1'b0, bcd_q, acc_q[Width-1:1]};
    for (int k = 0; k < Digits; k++) begin
      if (sh_bcd[4*k +: 4] >= 4'd8) sh_bcd[4*k +: 4] = sh_bcd[4*k +: 4] - 4'd3;
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d    = state_q;
    bcd_d      = bcd_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    err_flag_d = err_flag_q;
    binary_d   = binary_q;
    err_d      = err_q;
    done_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          bcd_d      = cap_bcd;
          acc_d      = '0;
          cnt_d      = CntW'(Width);
          err_flag_d = cap_bad;
          // Illegal operands skip the shift loop entirely.
          state_d    = cap_bad ? StDone : StShift;
        end
      end
      StShift: begin
        bcd_d = sh_bcd;
        acc_d = sh_acc;
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) state_d = StDone;
      end
      StDone: begin
        binary_d = err_flag_q ? '0 : acc_q;
        err_d    = err_flag_q;
        done_d   = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers; reset aborts any conversion without a Done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      bcd_q      <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      err_flag_q <= 1'b0;
      binary_q   <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bcd_q      <= bcd_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      err_flag_q <= err_flag_d;
      binary_q   <= binary_d;
      err_q      <= err_d;
      done_q     <= done_d;
    end
  end

  assign bus.binary = binary_q;
  assign bus.err    = err_q;
  assign bus.done   = done_q;
  assign bus.busy   = (state_q != StIdle);

endmodule

// File: tb/tb_bcd_to_binary.sv
// Directed bench for bcd_to_binary: reset state, valid conversions, illegal
// digits, blank digits, mid-conversion reset and ignored Start while busy.
module tb_bcd_to_binary;

  logic clk;
  logic rst;
  int   pass_cnt;
  int   total_cnt;

  bcd_to_binary_if #(.Digits(8), .Width(27)) bus ();

  bcd_to_binary #(.Digits(8), .Width(27)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse Start for one edge with operand d, then wait for Done (bounded).
  // lat counts edges after the accepting edge; -1 means Done never came.
  task automatic run_conv(input logic [31:0] d, output logic [26:0] bin,
                          output logic e, output int lat);
    bus.start  = 1'b1;
    bus.digits = d;
    @(posedge clk); #1;
    bus.start  = 1'b0;
    bus.digits = 32'h0;
    lat = -1;
    bin = '0;
    e   = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) begin
        lat = c;
        bin = bus.binary;
        e   = bus.err;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.digits = 32'h0;
    #12;
    total_cnt++;
    if ({bus.binary, bus.busy, bus.done, bus.err} !== 30'h0)
      $display("FAIL reset_outputs: got binary=%0d busy=%b done=%b err=%b, want all 0",
               bus.binary, bus.busy, bus.done, bus.err);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int busy_cnt;
    int done_cnt;
    logic [26:0] bin;
    logic e;
    bus.start  = 1'b1;
    bus.digits = 32'h00000270;
    @(posedge clk); #1;
    bus.start  = 1'b0;
    busy_cnt = 0;
    for (int c = 0; c < 100 && bus.busy === 1'b1; c++) begin
      busy_cnt++;
      @(posedge clk); #1;
    end
    total_cnt++;
    if (busy_cnt !== 28) $display("FAIL basic_busy_len: got %0d cycles, want 28", busy_cnt);
    else pass_cnt++;
    total_cnt++;
    if (bus.done !== 1'b1) $display("FAIL basic_done: got %b, want 1", bus.done);
    else pass_cnt++;
    bin = bus.binary;
    e   = bus.err;
    total_cnt++;
    if (bin !== 27'd270 || e !== 1'b0)
      $display("FAIL basic_result: got %0d err=%b, want 270 err=0", bin, e);
    else pass_cnt++;
    done_cnt = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) done_cnt++;
    end
    total_cnt++;
    if (done_cnt !== 0 || bus.binary !== 27'd270)
      $display("FAIL basic_hold: got extra_done=%0d binary=%0d, want 0 and 270",
               done_cnt, bus.binary);
    else pass_cnt++;
  endtask

  task automatic test_max();
    logic [26:0] bin;
    logic e;
    int lat;
    run_conv(32'h99999999, bin, e, lat);
    total_cnt++;
    if (lat !== 28) $display("FAIL max_latency: got %0d, want 28", lat);
    else pass_cnt++;
    total_cnt++;
    if (bin !== 27'h5F5E0FF || e !== 1'b0)
      $display("FAIL max_result: got %h err=%b, want 5f5e0ff err=0", bin, e);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [26:0] bin;
    logic e;
    int lat;
    int done_cnt;
    bus.start  = 1'b1;
    bus.digits = 32'h00012345;
    @(posedge clk); #1;
    bus.start  = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
    end
    #1;
    rst = 1'b1;
    #1;
    total_cnt++;
    if ({bus.binary, bus.busy, bus.done, bus.err} !== 30'h0)
      $display("FAIL midreset_outputs: got binary=%0d busy=%b done=%b err=%b, want all 0",
               bus.binary, bus.busy, bus.done, bus.err);
    else pass_cnt++;
    done_cnt = 0;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) done_cnt++;
    end
    rst = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1 || bus.busy === 1'b1) done_cnt++;
    end
    total_cnt++;
    if (done_cnt !== 0) $display("FAIL midreset_no_done: got %0d activity cycles, want 0",
                                 done_cnt);
    else pass_cnt++;
    run_conv(32'h00012345, bin, e, lat);
    total_cnt++;
    if (lat !== 28 || bin !== 27'd12345 || e !== 1'b0)
      $display("FAIL midreset_reconvert: got lat=%0d bin=%0d err=%b, want 28 12345 0",
               lat, bin, e);
    else pass_cnt++;
  endtask

  task automatic test_invalid();
    logic [26:0] bin;
    logic e;
    int lat;
    run_conv(32'h000001A0, bin, e, lat);
    total_cnt++;
    if (lat !== 1) $display("FAIL invalid_latency: got %0d, want 1", lat);
    else pass_cnt++;
    total_cnt++;
    if (bin !== 27'd0 || e !== 1'b1)
      $display("FAIL invalid_result: got %0d err=%b, want 0 err=1", bin, e);
    else pass_cnt++;
    @(posedge clk); #1;
    run_conv(32'h00000192, bin, e, lat);
    total_cnt++;
    if (lat !== 28 || bin !== 27'd192 || e !== 1'b0)
      $display("FAIL after_invalid: got lat=%0d bin=%0d err=%b, want 28 192 0", lat, bin, e);
    else pass_cnt++;
  endtask

  task automatic test_blank();
    logic [26:0] bin;
    logic e;
    int lat;
    @(posedge clk); #1;
    run_conv(32'hFFFFF192, bin, e, lat);
`ifdef BCD2BIN_BLANK_EN
    total_cnt++;
    if (lat !== 28 || bin !== 27'd192 || e !== 1'b0)
      $display("FAIL blank_result: got lat=%0d bin=%0d err=%b, want 28 192 0", lat, bin, e);
    else pass_cnt++;
`else
    total_cnt++;
    if (lat !== 1 || bin !== 27'd0 || e !== 1'b1)
      $display("FAIL blank_result: got lat=%0d bin=%0d err=%b, want 1 0 1", lat, bin, e);
    else pass_cnt++;
`endif
  endtask

  task automatic test_back_to_back();
    int done_cnt;
    int done_cyc;
    logic [26:0] bin;
    @(posedge clk); #1;
    bus.start  = 1'b1;
    bus.digits = 32'h00000270;
    @(posedge clk); #1;
    bus.start  = 1'b0;
    done_cnt = 0;
    done_cyc = -1;
    bin = '0;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) begin
        done_cnt++;
        done_cyc = c;
        bin = bus.binary;
      end
      if (c == 5) begin
        bus.start  = 1'b1;
        bus.digits = 32'h00000999;
      end else begin
        bus.start  = 1'b0;
      end
    end
    total_cnt++;
    if (done_cnt !== 1) $display("FAIL b2b_done_count: got %0d, want 1", done_cnt);
    else pass_cnt++;
    total_cnt++;
    if (done_cyc !== 28 || bin !== 27'd270)
      $display("FAIL b2b_result: got cycle=%0d bin=%0d, want 28 270", done_cyc, bin);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_basic();
    test_max();
    test_reset_mid();
    test_invalid();
    test_blank();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
